// File: rtl/amba_axi4_lite_pkg.sv
// amba_axi4_lite_pkg: shared AXI4-Lite response codes and the address decode helper
package amba_axi4_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axi_resp_t;
  typedef struct packed {
    logic        hit;
    logic [15:0] idx;
  } dec_t;
  function automatic dec_t decode(input logic [63:0] addr, input int ofs, input int iw);
    dec_t d;
    d.hit = (addr >> (ofs + iw)) == 64'd0;
    d.idx = 16'((addr >> ofs) & ((64'd1 << iw) - 64'd1));
    return d;
  endfunction
endpackage

// File: rtl/amba_axi4_lite_reg_array.sv
// amba_axi4_lite_reg_array: byte-writable register bank, index 0 reads a constant ID
module amba_axi4_lite_reg_array #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 'h0A11_0001,
  localparam int IW = $clog2(NUM_REGS),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [IW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  always_ff @(posedge clk)
    if (rst)
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    else if (we && widx != '0)
      for (int b = 0; b < STRB_WIDTH; b++)
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
  // Combinational read gives pre-write data when a commit lands on the same edge
  assign rdata = ridx == '0 ? ID_VALUE : mem[ridx];
endmodule

// File: rtl/amba_axi4_lite_reg_slave.sv
// amba_axi4_lite_reg_slave: AXI4-Lite slave with independent AW/W slots, registered B and R channels
module amba_axi4_lite_reg_slave
  import amba_axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS = 16,
  parameter logic [63:0] ID_VALUE = 64'h0A11_0001,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDRESS_WIDTH-1:0] AWADDR,
  input  logic [2:0]               AWPROT,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_WIDTH-1:0]    WDATA,
  input  logic [STRB_WIDTH-1:0]    WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [ADDRESS_WIDTH-1:0] ARADDR,
  input  logic [2:0]               ARPROT,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY
);
  localparam int OFS = $clog2(STRB_WIDTH);
  localparam int IW = $clog2(NUM_REGS);
  logic                     aw_full, w_full, commit, ar_hs, w_ok;
  logic [ADDRESS_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0]    w_data, rd_val;
  logic [STRB_WIDTH-1:0]    w_strb;
  dec_t                     wdec, rdec;
  logic                     unused;
  always_comb begin
    wdec = decode(64'(aw_addr), OFS, IW);
    rdec = decode(64'(ARADDR), OFS, IW);
    w_ok = wdec.hit && wdec.idx != 16'd0;
    commit = aw_full && w_full && (!BVALID || BREADY);
    ar_hs = ARVALID && !RVALID;
  end
  assign AWREADY = !aw_full;
  assign WREADY = !w_full;
  assign ARREADY = !RVALID;
  assign unused = ^{AWPROT, ARPROT, wdec.idx, rdec.idx};
  always_ff @(posedge ACLK)
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      BVALID <= 1'b0;
      BRESP <= OKAY;
      RVALID <= 1'b0;
      RDATA <= '0;
      RRESP <= OKAY;
    end else begin
      aw_full <= commit ? 1'b0 : aw_full | AWVALID;
      w_full <= commit ? 1'b0 : w_full | WVALID;
      BVALID <= commit | (BVALID & !BREADY);
      RVALID <= ar_hs | (RVALID & !RREADY);
      if (commit) BRESP <= w_ok ? OKAY : SLVERR;
      if (ar_hs) begin
        RDATA <= rdec.hit ? rd_val : '0;
        RRESP <= rdec.hit ? OKAY : SLVERR;
      end
    end
  // Payload capture needs no reset; the full flags qualify it
  always_ff @(posedge ACLK) begin
    if (AWVALID && !aw_full) aw_addr <= AWADDR;
    if (WVALID && !w_full) begin
      w_data <= WDATA;
      w_strb <= WSTRB;
    end
  end
  amba_axi4_lite_reg_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS),
    .ID_VALUE(DATA_WIDTH'(ID_VALUE))
  ) u_regs (
    .clk(ACLK),
    .rst(ARESET),
    .we(commit && w_ok),
    .widx(wdec.idx[IW-1:0]),
    .wdata(w_data),
    .wstrb(w_strb),
    .ridx(rdec.idx[IW-1:0]),
    .rdata(rd_val)
  );
endmodule

// File: tb/tb_amba_axi4_lite_reg_slave.sv
// tb_amba_axi4_lite_reg_slave: directed plus randomized bench against an array-based register model
module tb_amba_axi4_lite_reg_slave;
  localparam int NR = 16;
  localparam logic [63:0] ID = 64'h0A11_0001;
  logic        ACLK = 0, ARESET = 1;
  logic [31:0] AWADDR = 0, ARADDR = 0;
  logic [2:0]  AWPROT = 0, ARPROT = 0;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [63:0] WDATA = 0, RDATA;
  logic [7:0]  WSTRB = 0;
  logic [1:0]  BRESP, RRESP;
  int checks = 0, errors = 0;
  logic [63:0] mdl [NR];

  amba_axi4_lite_reg_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic hit(input logic [31:0] a);
    return (a >> 7) == 32'd0;
  endfunction
  function automatic int idx(input logic [31:0] a);
    return int'(a[6:3]);
  endfunction
  function automatic logic [1:0] exp_wresp(input logic [31:0] a);
    return (hit(a) && idx(a) != 0) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    return hit(a) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [63:0] exp_rd(input logic [31:0] a);
    if (!hit(a)) return 64'd0;
    return idx(a) == 0 ? ID : mdl[idx(a)];
  endfunction
  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    if (exp_wresp(a) == 2'b00)
      for (int b = 0; b < 8; b++)
        if (s[b]) mdl[idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic model_clear;
    for (int r = 0; r < NR; r++) mdl[r] = 64'd0;
  endtask

  // mode 0: AW and W together, 1: AW leads W by gap, 2: W leads AW by gap
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int mode, input int gap, input int bdly);
    logic aw_done = 0, w_done = 0, hs_aw, hs_w;
    logic [1:0] er = exp_wresp(a);
    AWADDR = a; WDATA = d; WSTRB = s;
    for (int c = 0; c < 100 && !(aw_done && w_done); c++) begin
      if (!aw_done) AWVALID = (mode != 2) || (c >= gap);
      if (!w_done) WVALID = (mode != 1) || (c >= gap);
      if (w_done && !aw_done) check("w_slot_held", WREADY, 0);
      if (aw_done && !w_done) check("aw_slot_held", AWREADY, 0);
      hs_aw = AWVALID && AWREADY;
      hs_w = WVALID && WREADY;
      tick;
      if (hs_aw) begin aw_done = 1; AWVALID = 0; end
      if (hs_w) begin w_done = 1; WVALID = 0; end
    end
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    check("b_lat_n1", BVALID, 0);
    tick;
    check("b_lat_n2", BVALID, 1);
    check("bresp", BRESP, er);
    model_write(a, d, s);
    for (int k = 0; k < bdly; k++) begin
      tick;
      check("b_hold", BVALID, 1);
      check("bresp_hold", BRESP, er);
    end
    BREADY = 1;
    tick;
    BREADY = 0;
    check("b_clear", BVALID, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int rdly);
    logic [63:0] e = exp_rd(a);
    logic [1:0] rr = exp_rresp(a);
    ARADDR = a;
    ARVALID = 1;
    for (int c = 0; c < 50 && !ARREADY; c++) tick;
    check("ar_ready", ARREADY, 1);
    tick;
    ARVALID = 0;
    check("rvalid", RVALID, 1);
    check("rdata", RDATA, e);
    check("rresp", RRESP, rr);
    for (int k = 0; k < rdly; k++) begin
      check("ar_blocked", ARREADY, 0);
      tick;
      check("r_hold", RVALID, 1);
      check("rdata_hold", RDATA, e);
      check("rresp_hold", RRESP, rr);
    end
    RREADY = 1;
    tick;
    RREADY = 0;
    check("r_clear", RVALID, 0);
  endtask

  initial begin
    logic [63:0] old_v, new_v, d;
    logic [31:0] a;
    int r;
    model_clear();
    tick;
    tick;
    ARESET = 0;
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 1);
    check("rst_arready", ARREADY, 1);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rresp", RRESP, 0);

    do_write(32'h08, 64'h1122334455667788, 8'hFF, 0, 0, 0);
    do_read(32'h08, 0);
    check("t1_const", mdl[1], 64'h1122334455667788);
    do_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2, 4, 0);
    do_read(32'h10, 0);
    check("t2_const", mdl[2], 64'h0000_0000_FFFF_FFFF);
    do_write(32'h00, 64'hDEAD_BEEF_0000_1111, 8'hFF, 0, 0, 0);
    do_write(32'h1000, 64'hCAFE_0000_1234_5678, 8'hFF, 1, 2, 0);
    do_read(32'h00, 0);
    do_read(32'h1000, 0);
    do_read(32'h08, 0);

    // Held B with a second write parked in the slots
    AWADDR = 32'h20; WDATA = 64'h0102030405060708; WSTRB = 8'hFF;
    AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    check("bp_b1_valid", BVALID, 1);
    check("bp_slots_free", AWREADY, 1);
    model_write(32'h20, WDATA, WSTRB);
    AWADDR = 32'h00; WDATA = 64'h55; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    for (int k = 0; k < 10; k++) begin
      check("bp_awready", AWREADY, 0);
      check("bp_wready", WREADY, 0);
      check("bp_bvalid", BVALID, 1);
      check("bp_bresp", BRESP, 2'b00);
      tick;
    end
    BREADY = 1;
    tick;
    check("bp_b2_valid", BVALID, 1);
    check("bp_b2_resp", BRESP, 2'b10);
    tick;
    BREADY = 0;
    check("bp_b2_clear", BVALID, 0);
    do_read(32'h20, 0);

    do_read(32'h08, 5);

    // Same-edge read and commit on one register
    do_write(32'h18, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 0, 0, 0);
    old_v = mdl[3];
    new_v = 64'h1234_5678_9ABC_DEF0;
    AWADDR = 32'h18; WDATA = new_v; WSTRB = 8'hFF; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    ARADDR = 32'h18; ARVALID = 1;
    check("same_arready", ARREADY, 1);
    tick;
    ARVALID = 0;
    check("same_old_data", RDATA, old_v);
    check("same_bvalid", BVALID, 1);
    model_write(32'h18, new_v, 8'hFF);
    BREADY = 1; RREADY = 1;
    tick;
    BREADY = 0; RREADY = 0;
    do_read(32'h18, 0);

    // Reset with the slots full and a response pending
    AWADDR = 32'h28; WDATA = 64'h77; WSTRB = 8'hFF; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    AWADDR = 32'h30; AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    check("mid_bvalid", BVALID, 1);
    check("mid_awready", AWREADY, 0);
    ARESET = 1;
    tick;
    ARESET = 0;
    model_clear();
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_rvalid", RVALID, 0);
    check("mid_rst_awready", AWREADY, 1);
    check("mid_rst_wready", WREADY, 1);
    check("mid_rst_arready", ARREADY, 1);
    tick;
    check("mid_rst_no_commit", BVALID, 0);
    do_read(32'h08, 0);
    do_read(32'h30, 0);

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'($urandom_range(0, 7));
      else if (r == 1) a = (32'h80 << $urandom_range(0, 24)) | 32'($urandom_range(0, 127));
      else a = {25'd0, 4'($urandom_range(1, 15)), 3'($urandom_range(0, 7))};
      d = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0)
        do_write(a, d, 8'($urandom_range(0, 255)), $urandom_range(0, 2),
                 $urandom_range(0, 4), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
